pca_const_loader: RTL and testbench

Initiator side of the track fitter's constant-memory port: streams PCA coefficient words from an upstream source into the fitter as a sequence of single-cycle write strobes on the mem_en / mem_rd_wr / mem_add / mem_data bus. It sits between the configuration source (DMA, testbench driver or ROM reader) and the TrackFitterRTL memory port. It also reports completion, a running checksum and a source-starvation timeout.

---
 rtl/pca_const_loader.sv | 166 ++++++++++++++++
 tb/tb_pca_const_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pca_const_loader.sv
// pca_const_loader: streams PCA coefficient words from an upstream source
// into the track fitter's constant memory as single-cycle write strobes.
// It also reports completion, a running checksum of the words written, and
// an error if the source stops delivering words for too long during a load.
module pca_const_loader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 9,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [CNT_W-1:0]  word_count_i,
    input  logic              src_valid_i,
    input  logic [DATA_W-1:0] src_data_i,
    output logic              src_ready_o,
    output logic              mem_en_o,
    output logic              mem_rd_wr_o,
    output logic [ADDR_W-1:0] mem_add_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [DATA_W-1:0] checksum_o
);

    // The starve counter only has to reach TIMEOUT, so it is sized for that.
    localparam int STARVE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   checksum_q,  checksum_d;
    logic [STARVE_W-1:0] starve_q,    starve_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_rd_wr_q, mem_rd_wr_d;
    logic [ADDR_W-1:0]   mem_add_q,   mem_add_d;
    logic [DATA_W-1:0]   mem_data_q,  mem_data_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;
    logic                handshake;

    // The source may hand over a word whenever a load still has words left.
    always_comb begin
        src_ready_o = (state_q == LOAD) && (remaining_q != '0);
        handshake   = src_valid_i && src_ready_o;
    end

    // Next-state logic: start handling, word transfer, and starvation timeout.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        checksum_d  = checksum_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_rd_wr_d = 1'b0;
        mem_add_d   = mem_add_q;
        mem_data_d  = mem_data_q;
        done_d      = 1'b0;
        error_d     = error_q;

        case (state_q)
            IDLE, ERR: begin
                if (start_i) begin
                    checksum_d = '0;
                    error_d    = 1'b0;
                    starve_d   = '0;
                    if (word_count_i != '0) begin
                        addr_d      = start_addr_i;
                        remaining_d = word_count_i;
                        state_d     = LOAD;
                    end else begin
                        // An empty load completes immediately without writes.
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            LOAD: begin
                if (handshake) begin
                    mem_en_d    = 1'b1;
                    mem_rd_wr_d = 1'b1;
                    mem_add_d   = addr_q;
                    mem_data_d  = src_data_i;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    checksum_d  = checksum_q + src_data_i;
                    starve_d    = '0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (!src_valid_i) begin
                    if (starve_q == STARVE_LAST) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD);
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            checksum_q  <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_rd_wr_q <= 1'b0;
            mem_add_q   <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            checksum_q  <= checksum_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_rd_wr_q <= mem_rd_wr_d;
            mem_add_q   <= mem_add_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Registered outputs are driven straight from their flops.
    always_comb begin
        mem_en_o    = mem_en_q;
        mem_rd_wr_o = mem_rd_wr_q;
        mem_add_o   = mem_add_q;
        mem_data_o  = mem_data_q;
        busy_o      = busy_q;
        done_o      = done_q;
        error_o     = error_q;
        checksum_o  = checksum_q;
    end

endmodule

// File: tb/tb_pca_const_loader.sv
// tb_pca_const_loader: directed and randomized loads checked against a
// transaction-level model of the expected write sequence.
module tb_pca_const_loader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = 9;
    localparam int TIMEOUT = 4;
    localparam int CYCLE_BOUND = 400;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] startAddr = '0;
    logic [CNT_W-1:0]  wordCount = '0;
    logic              srcValid = 1'b0;
    logic [DATA_W-1:0] srcData = '0;
    logic              srcReady;
    logic              memEn;
    logic              memRdWr;
    logic [ADDR_W-1:0] memAdd;
    logic [DATA_W-1:0] memData;
    logic              busy;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] checksum;

    int checks = 0;
    int passes = 0;

    logic [ADDR_W-1:0] lastAddr = '0;
    logic [DATA_W-1:0] lastData = '0;

    pca_const_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .start_addr_i(startAddr),
        .word_count_i(wordCount),
        .src_valid_i (srcValid),
        .src_data_i  (srcData),
        .src_ready_o (srcReady),
        .mem_en_o    (memEn),
        .mem_rd_wr_o (memRdWr),
        .mem_add_o   (memAdd),
        .mem_data_o  (memData),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .checksum_o  (checksum)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Outputs that must be quiet when no load is running.
    task automatic checkIdle(input string tag, input logic expErr,
                             input logic [DATA_W-1:0] expSum);
        checkOutput({tag, "_mem_en"},    memEn,    0);
        checkOutput({tag, "_mem_rd_wr"}, memRdWr,  0);
        checkOutput({tag, "_busy"},      busy,     0);
        checkOutput({tag, "_src_ready"}, srcReady, 0);
        checkOutput({tag, "_done"},      done,     0);
        checkOutput({tag, "_error"},     error,    expErr);
        checkOutput({tag, "_checksum"},  checksum, expSum);
        checkOutput({tag, "_mem_add"},   memAdd,   lastAddr);
        checkOutput({tag, "_mem_data"},  memData,  lastData);
    endtask

    // One load: start pulse, then a source pattern, with every cycle compared
    // against the expected write list (address start+i, data in order, sum).
    // dataMode: 0 random, 1 counting 1..n, 2 all ones.
    // patLen>0 uses patBits (LSB first) as the src_valid pattern.
    // injectAt>=0 pulses a stray start on that cycle.
    // starveAfter>=0 drops src_valid after that many words.
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int count,
                                 input int dataMode, input int validPct,
                                 input logic [31:0] patBits, input int patLen,
                                 input int injectAt, input int starveAfter,
                                 output logic timedOutOut,
                                 output logic [DATA_W-1:0] sumOut);
        logic [ADDR_W-1:0] mAddr;
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] d;
        logic              v;
        logic              timedOut;
        int                left;
        int                zeros;
        int                hsCount;
        int                cyc;

        start     = 1'b1;
        startAddr = addr;
        wordCount = count[CNT_W-1:0];
        srcValid  = 1'b0;
        srcData   = $urandom;
        tick();
        start = 1'b0;
        checkOutput("start_busy",      busy,     1);
        checkOutput("start_src_ready", srcReady, 1);
        checkOutput("start_checksum",  checksum, 0);
        checkOutput("start_error",     error,    0);
        checkOutput("start_done",      done,     0);
        checkOutput("start_mem_en",    memEn,    0);

        mAddr    = addr;
        left     = count;
        sum      = '0;
        zeros    = 0;
        hsCount  = 0;
        cyc      = 0;
        timedOut = 1'b0;

        while (left > 0 && !timedOut && cyc < CYCLE_BOUND) begin
            if (starveAfter >= 0 && hsCount >= starveAfter)
                v = 1'b0;
            else if (patLen > 0 && cyc < patLen)
                v = patBits[cyc];
            else if (zeros >= TIMEOUT - 1)
                v = 1'b1;
            else
                v = ($urandom_range(99) < validPct);

            case (dataMode)
                1:       d = 32'(hsCount + 1);
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase

            srcValid = v;
            srcData  = d;
            start    = (cyc == injectAt);
            if (cyc == injectAt) begin
                startAddr = 8'hAA;
                wordCount = 9'd7;
            end
            tick();

            checkOutput("mem_en",    memEn,   v);
            checkOutput("mem_rd_wr", memRdWr, v);
            if (v) begin
                checkOutput("mem_add",  memAdd,  mAddr);
                checkOutput("mem_data", memData, d);
                lastAddr = mAddr;
                lastData = d;
                mAddr    = mAddr + 8'd1;
                left     = left - 1;
                sum      = sum + d;
                zeros    = 0;
                hsCount  = hsCount + 1;
            end else begin
                checkOutput("hold_mem_add",  memAdd,  lastAddr);
                checkOutput("hold_mem_data", memData, lastData);
                zeros = zeros + 1;
                if (zeros == TIMEOUT)
                    timedOut = 1'b1;
            end

            checkOutput("done",      done,     (v && left == 0));
            checkOutput("busy",      busy,     (left != 0 && !timedOut));
            checkOutput("src_ready", srcReady, (left != 0 && !timedOut));
            checkOutput("error",     error,    timedOut);
            checkOutput("checksum",  checksum, sum);
            cyc = cyc + 1;
        end

        start    = 1'b0;
        srcValid = 1'b0;
        checkOutput("loop_bound", (cyc < CYCLE_BOUND), 1);
        tick();
        checkIdle("after", timedOut, sum);
        timedOutOut = timedOut;
        sumOut      = sum;
    endtask

    // Directed scenarios followed by randomized loads.
    initial begin
        logic              to;
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] w;

        $display("[TB] reset");
        #12;
        checkIdle("reset", 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checkIdle("post_reset", 0, 0);

        $display("[TB] basic load 0x10 x4");
        applyStimulus(8'h10, 4, 1, 100, 32'h0, 0, -1, -1, to, s);
        checkOutput("basic_sum", checksum, 32'd10);
        checkOutput("basic_last_addr", memAdd, 8'h13);

        $display("[TB] address wrap");
        applyStimulus(8'hFE, 3, 2, 100, 32'h0, 0, -1, -1, to, s);
        checkOutput("wrap_sum", checksum, 32'hFFFF_FFFD);
        checkOutput("wrap_last_addr", memAdd, 8'h00);

        $display("[TB] bubbles");
        applyStimulus(8'h20, 3, 0, 100, 32'b101001, 6, -1, -1, to, s);
        checkOutput("bubble_no_timeout", to, 0);

        $display("[TB] starvation timeout");
        applyStimulus(8'h30, 5, 0, 100, 32'h0, 0, -1, 2, to, s);
        checkOutput("timeout_seen", to, 1);
        tick();
        checkIdle("err_hold", 1, s);

        $display("[TB] reload from error");
        applyStimulus(8'h50, 4, 0, 80, 32'h0, 0, -1, -1, to, s);
        checkOutput("reload_no_timeout", to, 0);

        $display("[TB] stray start during load");
        applyStimulus(8'h60, 8, 0, 100, 32'h0, 0, 2, -1, to, s);

        $display("[TB] empty load from error");
        applyStimulus(8'h70, 3, 0, 100, 32'h0, 0, -1, 1, to, s);
        checkOutput("timeout2_seen", to, 1);
        start     = 1'b1;
        wordCount = '0;
        tick();
        start = 1'b0;
        checkOutput("empty_done",     done,     1);
        checkOutput("empty_error",    error,    0);
        checkOutput("empty_checksum", checksum, 0);
        checkOutput("empty_busy",     busy,     0);
        checkOutput("empty_mem_en",   memEn,    0);
        tick();
        checkIdle("empty_after", 0, 0);

        $display("[TB] reset mid-load");
        start     = 1'b1;
        startAddr = 8'h40;
        wordCount = 9'd6;
        tick();
        start    = 1'b0;
        srcValid = 1'b1;
        w        = $urandom;
        srcData  = w;
        tick();
        checkOutput("rst_w1_en",  memEn,  1);
        checkOutput("rst_w1_add", memAdd, 8'h40);
        srcData = $urandom;
        tick();
        checkOutput("rst_w2_en",  memEn,  1);
        checkOutput("rst_w2_add", memAdd, 8'h41);
        #2;
        rst = 1'b1;
        #1;
        lastAddr = '0;
        lastData = '0;
        checkIdle("rst_async", 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkIdle("rst_after", 0, 0);
        end
        srcValid = 1'b0;

        $display("[TB] randomized loads");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8'($urandom_range(255)), int'($urandom_range(20, 1)), 0, 70,
                          32'h0, 0, -1, -1, to, s);
            checkOutput("rand_no_timeout", to, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
